// File: rtl/perlin_anim_sched.sv
// -----------------------------------------------------------------------------
// perlin_anim_sched
// Animation scheduler for the Perlin noise datapath. Owns the time coordinate
// `t` and advances it once per selected frame under a run / pause /
// single-step state machine. Configuration arrives through a valid/ready port
// into a shadow register and is promoted to the active set only on a
// frame_tick, so a frame never renders with a mid-frame time change.
//
// Ports:
//   clk         pixel clock
//   reset       asynchronous active-high reset
//   frame_tick  one-cycle pulse on the first cycle of each frame
//   cmd_run     pulse: enter RUN
//   cmd_pause   pulse: enter PAUSED
//   cmd_step    pulse: arm one advance while paused
//   cfg_valid   configuration offer
//   cfg_ready   registered: shadow register is free
//   cfg_step    amount added/subtracted per advance
//   cfg_div     advance every cfg_div+1 frames (RUN only)
//   cfg_mode    00 wrap-forward, 01 ping-pong, 10 wrap-reverse, 11 as 00
//   cfg_limit   upper bound for ping-pong mode
//   t           registered time coordinate
//   t_upd       registered one-cycle pulse with each advanced t
//   running     registered: high in RUN
// -----------------------------------------------------------------------------
module perlin_anim_sched #(
    parameter int T_WIDTH   = 16,
    parameter int DIV_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 cmd_run,
    input  logic                 cmd_pause,
    input  logic                 cmd_step,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [7:0]           cfg_step,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [1:0]           cfg_mode,
    input  logic [T_WIDTH-1:0]   cfg_limit,
    output logic [T_WIDTH-1:0]   t,
    output logic                 t_upd,
    output logic                 running
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_PAUSED = 2'd1;
    localparam logic [1:0] ST_STEP   = 2'd2;

    localparam logic [1:0] MODE_FWD  = 2'b00;
    localparam logic [1:0] MODE_PP   = 2'b01;
    localparam logic [1:0] MODE_REV  = 2'b10;

    // Registers
    logic [1:0]           state_r;
    logic                 dir_r;          // 0 = up, 1 = down (ping-pong only)
    logic [DIV_WIDTH-1:0] frame_cnt_r;
    logic                 shd_full_r;
    logic [7:0]           shd_step_r;
    logic [DIV_WIDTH-1:0] shd_div_r;
    logic [1:0]           shd_mode_r;
    logic [T_WIDTH-1:0]   shd_limit_r;
    logic [7:0]           act_step_r;
    logic [DIV_WIDTH-1:0] act_div_r;
    logic [1:0]           act_mode_r;
    logic [T_WIDTH-1:0]   act_limit_r;
    logic [T_WIDTH-1:0]   t_r;
    logic                 t_upd_r;
    logic                 cfg_ready_r;
    logic                 running_r;

    // Combinational
    logic                 cfg_xfer_s;
    logic                 apply_s;
    logic [7:0]           eff_step_s;
    logic [DIV_WIDTH-1:0] eff_div_s;
    logic [1:0]           eff_mode_s;
    logic [T_WIDTH-1:0]   eff_limit_s;
    logic                 clamp_s;
    logic [T_WIDTH-1:0]   t_base_s;
    logic                 dir_base_s;
    logic [T_WIDTH:0]     step_ext_s;
    logic [T_WIDTH:0]     sum_s;
    logic [T_WIDTH-1:0]   diff_s;
    logic [T_WIDTH-1:0]   t_adv_s;
    logic                 dir_adv_s;
    logic                 advance_s;
    logic [DIV_WIDTH-1:0] frame_cnt_next_s;
    logic [1:0]           state_next_s;

    // Handshake, effective config for this tick and ping-pong clamp on apply
    always_comb begin
        cfg_xfer_s = cfg_valid & cfg_ready_r;
        apply_s    = frame_tick & shd_full_r;
        if (apply_s) begin
            eff_step_s  = shd_step_r;
            eff_div_s   = shd_div_r;
            eff_mode_s  = shd_mode_r;
            eff_limit_s = shd_limit_r;
        end else begin
            eff_step_s  = act_step_r;
            eff_div_s   = act_div_r;
            eff_mode_s  = act_mode_r;
            eff_limit_s = act_limit_r;
        end
        // A newly applied ping-pong config pulls t back inside its range first
        clamp_s = apply_s & (eff_mode_s == MODE_PP) & (t_r > eff_limit_s);
        if (clamp_s) begin
            t_base_s   = eff_limit_s;
            dir_base_s = 1'b1;
        end else begin
            t_base_s   = t_r;
            dir_base_s = dir_r;
        end
    end

    // Advance arithmetic; the carry bit of sum_s keeps the limit compare exact
    always_comb begin
        step_ext_s = {{(T_WIDTH-7){1'b0}}, eff_step_s};
        sum_s      = {1'b0, t_base_s} + step_ext_s;
        diff_s     = t_base_s - step_ext_s[T_WIDTH-1:0];
        t_adv_s    = sum_s[T_WIDTH-1:0];
        dir_adv_s  = dir_base_s;
        case (eff_mode_s)
            MODE_PP: begin
                if (!dir_base_s) begin
                    if (sum_s >= {1'b0, eff_limit_s}) begin
                        t_adv_s   = eff_limit_s;
                        dir_adv_s = 1'b1;
                    end else begin
                        t_adv_s   = sum_s[T_WIDTH-1:0];
                        dir_adv_s = 1'b0;
                    end
                end else begin
                    if ({1'b0, t_base_s} <= step_ext_s) begin
                        t_adv_s   = {T_WIDTH{1'b0}};
                        dir_adv_s = 1'b0;
                    end else begin
                        t_adv_s   = diff_s;
                        dir_adv_s = 1'b1;
                    end
                end
            end
            MODE_REV: t_adv_s = diff_s;
            MODE_FWD: t_adv_s = sum_s[T_WIDTH-1:0];
            default:  t_adv_s = sum_s[T_WIDTH-1:0];
        endcase
    end

    // Advance decision (against current state) and command-driven next state
    always_comb begin
        advance_s        = 1'b0;
        frame_cnt_next_s = frame_cnt_r;
        case (state_r)
            ST_RUN: begin
                if (frame_tick) begin
                    // >= so that lowering the divider never stalls the count
                    if (frame_cnt_r >= eff_div_s) begin
                        advance_s        = 1'b1;
                        frame_cnt_next_s = {DIV_WIDTH{1'b0}};
                    end else begin
                        advance_s        = 1'b0;
                        frame_cnt_next_s = frame_cnt_r + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
                    end
                end else begin
                    advance_s = 1'b0;
                end
            end
            ST_STEP: advance_s = frame_tick;
            default: advance_s = 1'b0;
        endcase

        if (cmd_pause) begin
            state_next_s = ST_PAUSED;
        end else if (cmd_step && (state_r == ST_PAUSED)) begin
            state_next_s = ST_STEP;
        end else if (cmd_run && (state_r != ST_RUN)) begin
            state_next_s     = ST_RUN;
            frame_cnt_next_s = {DIV_WIDTH{1'b0}};
        end else if ((state_r == ST_STEP) && frame_tick) begin
            state_next_s = ST_PAUSED;
        end else if ((state_r == ST_RUN) || (state_r == ST_PAUSED) || (state_r == ST_STEP)) begin
            state_next_s = state_r;
        end else begin
            // Unreachable encoding: recover to the reset state
            state_next_s = ST_RUN;
        end
    end

    // State machine, divider counter and running flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_RUN;
            frame_cnt_r <= {DIV_WIDTH{1'b0}};
            running_r   <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            frame_cnt_r <= frame_cnt_next_s;
            running_r   <= (state_next_s == ST_RUN);
        end
    end

    // Shadow/active configuration registers and cfg_ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shd_full_r  <= 1'b0;
            shd_step_r  <= 8'd0;
            shd_div_r   <= {DIV_WIDTH{1'b0}};
            shd_mode_r  <= MODE_FWD;
            shd_limit_r <= {T_WIDTH{1'b0}};
            act_step_r  <= 8'd1;
            act_div_r   <= {DIV_WIDTH{1'b0}};
            act_mode_r  <= MODE_FWD;
            act_limit_r <= {T_WIDTH{1'b1}};
            cfg_ready_r <= 1'b1;
        end else if (cfg_xfer_s) begin
            shd_full_r  <= 1'b1;
            shd_step_r  <= cfg_step;
            shd_div_r   <= cfg_div;
            shd_mode_r  <= cfg_mode;
            shd_limit_r <= cfg_limit;
            cfg_ready_r <= 1'b0;
        end else if (apply_s) begin
            shd_full_r  <= 1'b0;
            act_step_r  <= shd_step_r;
            act_div_r   <= shd_div_r;
            act_mode_r  <= shd_mode_r;
            act_limit_r <= shd_limit_r;
            cfg_ready_r <= 1'b1;
        end
    end

    // Time coordinate, direction and update pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_r     <= {T_WIDTH{1'b0}};
            dir_r   <= 1'b0;
            t_upd_r <= 1'b0;
        end else if (advance_s) begin
            t_r     <= t_adv_s;
            dir_r   <= dir_adv_s;
            t_upd_r <= 1'b1;
        end else begin
            // Clamp (if any) lands silently; otherwise t_base_s == t_r
            t_r     <= t_base_s;
            dir_r   <= dir_base_s;
            t_upd_r <= 1'b0;
        end
    end

    assign t         = t_r;
    assign t_upd     = t_upd_r;
    assign running   = running_r;
    assign cfg_ready = cfg_ready_r;

endmodule
